binary_centroid: RTL

Downstream consumer of the binarised pixel stream produced by the threshold stage. Each frame it accumulates the count, x-sum and y-sum of all set pixels. At the frame boundary it snapshots the sums and computes the integer centroid with a bit-serial divider. The result (x, y, area) feeds the tracking/overlay logic once per frame.

---
 rtl/binary_centroid.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/binary_centroid.sv
// rtl/binary_centroid.sv - per-frame centroid of a binarised pixel stream
module binary_centroid #(
  parameter int HCOUNT_W = 11,
  parameter int VCOUNT_W = 10,
  parameter int COUNT_W  = 20,
  parameter int SUM_W    = 32,
  parameter int MIN_AREA = 1
) (
  input  logic                clk_in,
  input  logic                rst_in_n,
  input  logic                valid_in,
  input  logic                pixel_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                new_frame_in,
  output logic [HCOUNT_W-1:0] x_out,
  output logic [VCOUNT_W-1:0] y_out,
  output logic [COUNT_W-1:0]  area_out,
  output logic                found_out,
  output logic                valid_out,
  output logic                busy_out
);

  localparam int BIT_W = $clog2(SUM_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SUM_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_X = 2'd1,
    DIV_Y = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // running per-frame accumulators
  logic [COUNT_W-1:0] count_acc;
  logic [SUM_W-1:0]   x_acc;
  logic [SUM_W-1:0]   y_acc;

  logic               pix_hit;
  logic [COUNT_W-1:0] count_inc;
  logic [SUM_W:0]     x_wide;
  logic [SUM_W:0]     y_wide;
  logic [SUM_W-1:0]   x_inc;
  logic [SUM_W-1:0]   y_inc;
  logic               snap_found;

  // divider state: the dividend shifts out of div_q's msb while quotient bits shift in at the lsb
  logic [COUNT_W-1:0]  cnt_r;
  logic [SUM_W-1:0]    ysum_r;
  logic                found_r;
  logic [SUM_W-1:0]    div_q;
  logic [COUNT_W-1:0]  rem;
  logic [BIT_W-1:0]    bit_cnt;
  logic [HCOUNT_W-1:0] qx;

  logic [COUNT_W:0]    trial;
  logic                trial_ge;
  logic [COUNT_W-1:0]  rem_next;
  logic [SUM_W-1:0]    q_next;
  logic                last_bit;

  // saturating increments so a very busy frame pins at all-ones instead of wrapping
  always_comb begin
    pix_hit    = valid_in & pixel_in;
    count_inc  = (&count_acc) ? count_acc : count_acc + COUNT_W'(1);
    x_wide     = {1'b0, x_acc} + (SUM_W+1)'(hcount_in);
    y_wide     = {1'b0, y_acc} + (SUM_W+1)'(vcount_in);
    x_inc      = x_wide[SUM_W] ? '1 : x_wide[SUM_W-1:0];
    y_inc      = y_wide[SUM_W] ? '1 : y_wide[SUM_W-1:0];
    snap_found = (count_acc >= COUNT_W'(MIN_AREA));
  end

  // accumulate set pixels; a boundary restarts the frame, keeping a coincident pixel
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      count_acc <= '0;
      x_acc     <= '0;
      y_acc     <= '0;
    end else if (new_frame_in) begin
      if (pix_hit) begin
        count_acc <= COUNT_W'(1);
        x_acc     <= SUM_W'(hcount_in);
        y_acc     <= SUM_W'(vcount_in);
      end else begin
        count_acc <= '0;
        x_acc     <= '0;
        y_acc     <= '0;
      end
    end else if (pix_hit) begin
      count_acc <= count_inc;
      x_acc     <= x_inc;
      y_acc     <= y_inc;
    end
  end

  // one restoring-division step: the remainder stays below the divisor, so COUNT_W bits hold it
  always_comb begin
    trial    = {rem, div_q[SUM_W-1]};
    trial_ge = (trial >= {1'b0, cnt_r});
    rem_next = trial_ge ? (trial[COUNT_W-1:0] - cnt_r) : trial[COUNT_W-1:0];
    q_next   = {div_q[SUM_W-2:0], trial_ge};
    last_bit = (bit_cnt == LAST_BIT);
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state decode; boundaries seen outside IDLE are simply ignored here
  always_comb begin
    state_next = state;
    busy_out   = (state != IDLE);
    case (state)
      IDLE: begin
        if (new_frame_in) begin
          state_next = snap_found ? DIV_X : DONE;
        end
      end
      DIV_X: begin
        if (last_bit) begin
          state_next = DIV_Y;
        end
      end
      DIV_Y: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // snapshot, divide x then y on the shared datapath, and publish the result
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      cnt_r     <= '0;
      ysum_r    <= '0;
      found_r   <= 1'b0;
      div_q     <= '0;
      rem       <= '0;
      bit_cnt   <= '0;
      qx        <= '0;
      x_out     <= '0;
      y_out     <= '0;
      area_out  <= '0;
      found_out <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (new_frame_in) begin
            cnt_r   <= count_acc;
            found_r <= snap_found;
            div_q   <= x_acc;
            ysum_r  <= y_acc;
            rem     <= '0;
            bit_cnt <= '0;
          end
        end
        DIV_X: begin
          bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
          if (last_bit) begin
            qx    <= q_next[HCOUNT_W-1:0];
            div_q <= ysum_r;
            rem   <= '0;
          end else begin
            div_q <= q_next;
            rem   <= rem_next;
          end
        end
        DIV_Y: begin
          bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
          div_q   <= q_next;
          rem     <= rem_next;
        end
        DONE: begin
          area_out  <= cnt_r;
          found_out <= found_r;
          valid_out <= 1'b1;
          if (found_r) begin
            x_out <= qx;
            y_out <= div_q[VCOUNT_W-1:0];
          end
        end
        default: begin
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
